// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the transmit and receive
// paths, default oversample ratio, data width and the parity helper.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Host-side byte handshake of the UART transmitter.
interface uart_tx_parity_if
  import uart_pkg::*;
;
  logic                   wr_en;
  logic [UART_DATA_W-1:0] din;
  logic                   tx_ready;
  logic                   tx_active;
  logic                   tx_done;

  modport master (output wr_en, output din,
                  input tx_ready, input tx_active, input tx_done);
  modport slave  (input wr_en, input din,
                  output tx_ready, output tx_active, output tx_done);
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, 1-2 stop bits,
// with a one-entry holding register so frames can run back to back.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            clken,
  uart_tx_parity_if.slave bus,
  output logic            tx
);

  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST   = 5'(OVERSAMPLE * STOP_BITS - 1);

  uart_state_e            state_r;
  logic [UART_DATA_W-1:0] shift_r;
  logic [UART_DATA_W-1:0] hold_r;
  logic                   hold_full_r;
  logic                   tx_ready_r;
  logic                   tx_active_r;
  logic                   tx_done_r;
  logic                   tx_r;
  logic                   parity_r;
  logic [3:0]             sample_r;
  logic [3:0]             bitpos_r;
  logic [4:0]             stop_cnt_r;

  logic wr_accept_s;
  logic bit_end_s;
  logic stop_end_s;
  logic unload_s;

  // Handshake decode and holding-register unload condition.
  always_comb begin
    wr_accept_s = bus.wr_en && tx_ready_r;
    bit_end_s   = (sample_r == SAMPLE_LAST);
    stop_end_s  = (stop_cnt_r == STOP_LAST);
    unload_s    = 1'b0;
    if (clken && hold_full_r) begin
      unload_s = (state_r == ST_IDLE) || ((state_r == ST_STOP) && stop_end_s);
    end else begin
      unload_s = 1'b0;
    end
  end

  // Holding register; tx_ready mirrors the slot being empty, so write and unload never collide.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_ready_r  <= 1'b1;
    end else if (wr_accept_s) begin
      hold_r      <= bus.din;
      hold_full_r <= 1'b1;
      tx_ready_r  <= 1'b0;
    end else if (unload_s) begin
      hold_full_r <= 1'b0;
      tx_ready_r  <= 1'b1;
    end else begin
      hold_full_r <= hold_full_r;
      tx_ready_r  <= tx_ready_r;
    end
  end

  // Frame FSM; everything advances on clken only, tx_done is a single-clock pulse.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      sample_r    <= 4'd0;
      bitpos_r    <= 4'd0;
      stop_cnt_r  <= 5'd0;
      tx_r        <= 1'b1;
      tx_active_r <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      if (clken) begin
        case (state_r)
          ST_IDLE: begin
            if (unload_s) begin
              shift_r     <= hold_r;
              parity_r    <= even_parity(hold_r);
              tx_r        <= 1'b0;
              sample_r    <= 4'd0;
              tx_active_r <= 1'b1;
              state_r     <= ST_START;
            end else begin
              tx_r        <= 1'b1;
              tx_active_r <= 1'b0;
            end
          end
          ST_START: begin
            if (bit_end_s) begin
              sample_r <= 4'd0;
              bitpos_r <= 4'd0;
              tx_r     <= shift_r[0];
              state_r  <= ST_DATA;
            end else begin
              sample_r <= sample_r + 4'd1;
            end
          end
          ST_DATA: begin
            if (!bit_end_s) begin
              sample_r <= sample_r + 4'd1;
            end else if (bitpos_r == 4'd7) begin
              sample_r   <= 4'd0;
              stop_cnt_r <= 5'd0;
              if (PARITY_EN != 0) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              sample_r <= 4'd0;
              bitpos_r <= bitpos_r + 4'd1;
              shift_r  <= {1'b0, shift_r[7:1]};
              tx_r     <= shift_r[1];
            end
          end
          ST_PARITY: begin
            if (bit_end_s) begin
              sample_r   <= 4'd0;
              stop_cnt_r <= 5'd0;
              tx_r       <= 1'b1;
              state_r    <= ST_STOP;
            end else begin
              sample_r <= sample_r + 4'd1;
            end
          end
          ST_STOP: begin
            if (!stop_end_s) begin
              stop_cnt_r <= stop_cnt_r + 5'd1;
            end else if (unload_s) begin
              // Queued byte starts on the very edge the stop bit ends: no idle gap.
              tx_done_r  <= 1'b1;
              stop_cnt_r <= 5'd0;
              shift_r    <= hold_r;
              parity_r   <= even_parity(hold_r);
              tx_r       <= 1'b0;
              sample_r   <= 4'd0;
              state_r    <= ST_START;
            end else begin
              tx_done_r   <= 1'b1;
              stop_cnt_r  <= 5'd0;
              tx_r        <= 1'b1;
              tx_active_r <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end
          default: begin
            tx_r        <= 1'b1;
            tx_active_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign tx            = tx_r;
  assign bus.tx_ready  = tx_ready_r;
  assign bus.tx_active = tx_active_r;
  assign bus.tx_done   = tx_done_r;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: frame shape, loopback decode, back-to-back,
// overrun, reset mid-frame and gated enable with two stop bits.
module tb_uart_tx_parity;

  logic clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  logic rst;
  logic clken1;
  logic clken2;
  logic tx1;
  logic tx2;

  uart_tx_parity_if bus1 ();
  uart_tx_parity_if bus2 ();

  uart_tx_parity dut1 (
    .clk_50m (clk_50m),
    .rst     (rst),
    .clken   (clken1),
    .bus     (bus1.slave),
    .tx      (tx1)
  );

  uart_tx_parity #(.STOP_BITS(2)) dut2 (
    .clk_50m (clk_50m),
    .rst     (rst),
    .clken   (clken2),
    .bus     (bus2.slave),
    .tx      (tx2)
  );

  int   n_assert  = 0;
  int   n_fail    = 0;
  int   done1_cnt = 0;
  int   cyc2      = 0;
  logic freeze    = 1'b1;

  // Count tx_done pulses of the default instance.
  always @(posedge clk_50m) begin
    if (bus1.tx_done === 1'b1) done1_cnt <= done1_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic tick2();
    clken2 = ((cyc2 % 4) == 0) && !freeze;
    tick();
    cyc2++;
  endtask

  task automatic write1(input logic [7:0] b);
    bus1.wr_en = 1'b1;
    bus1.din   = b;
    tick();
    bus1.wr_en = 1'b0;
  endtask

  task automatic wait_fall1(input string tag);
    int n = 0;
    while (tx1 !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, tx1}, 32'd0);
  endtask

  // Mid-bit sampler acting as the receiver; entered 'already' clocks after tx fell.
  task automatic capture1(input int already, output logic [7:0] d, output logic p, output logic s);
    repeat (8 - already) tick();
    chk("cap_start", {31'd0, tx1}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) tick();
      d[i] = tx1;
    end
    repeat (16) tick();
    p = tx1;
    repeat (16) tick();
    s = tx1;
  endtask

  initial begin
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic [10:0] line55;
    logic [11:0] line0f;
    int          snap;
    int          ticks;
    logic        exp_tx;

    rst = 1'b1;
    clken1 = 1'b1;
    clken2 = 1'b0;
    bus1.wr_en = 1'b0;
    bus1.din   = 8'h00;
    bus2.wr_en = 1'b0;
    bus2.din   = 8'h00;
    tick();
    tick();
    chk("rst_tx",     {31'd0, tx1},            32'd1);
    chk("rst_ready",  {31'd0, bus1.tx_ready},  32'd1);
    chk("rst_active", {31'd0, bus1.tx_active}, 32'd0);
    chk("rst_done",   {31'd0, bus1.tx_done},   32'd0);
    chk("rst_tx2",    {31'd0, tx2},            32'd1);
    rst = 1'b0;
    tick();

    // Frame check 0x55: start, 55h LSB first, parity 0, stop.
    line55 = 11'b10010101010;
    write1(8'h55);
    chk("f_ready_drop", {31'd0, bus1.tx_ready}, 32'd0);
    wait_fall1("f_fall");
    chk("f_active", {31'd0, bus1.tx_active}, 32'd1);
    for (int c = 0; c < 176; c++) begin
      chk("f_line", {31'd0, tx1}, {31'd0, line55[c / 16]});
      chk("f_nodone", {31'd0, bus1.tx_done}, 32'd0);
      tick();
    end
    chk("f_done",     {31'd0, bus1.tx_done},   32'd1);
    chk("f_idle_tx",  {31'd0, tx1},            32'd1);
    chk("f_inactive", {31'd0, bus1.tx_active}, 32'd0);
    chk("f_ready",    {31'd0, bus1.tx_ready},  32'd1);
    repeat (5) tick();

    // Loopback 0xA7: parity bit 1, receiver parity check 0.
    write1(8'hA7);
    wait_fall1("lb_fall");
    capture1(0, d, p, s);
    chk("lb_data",   {24'd0, d},        32'h0000_00A7);
    chk("lb_parity", {31'd0, p},        32'd1);
    chk("lb_perr",   {31'd0, ^{d, p}},  32'd0);
    chk("lb_stop",   {31'd0, s},        32'd1);
    repeat (8) tick();
    chk("lb_done",   {31'd0, bus1.tx_done}, 32'd1);
    repeat (5) tick();

    // Back-to-back and overrun: 0x01 on line, 0x80 held, 0xFF rejected.
    snap = done1_cnt;
    write1(8'h01);
    wait_fall1("bb_fall");
    chk("bb_ready_free", {31'd0, bus1.tx_ready}, 32'd1);
    write1(8'h80);
    chk("bb_ready_held", {31'd0, bus1.tx_ready}, 32'd0);
    write1(8'hFF);
    chk("ov_ready", {31'd0, bus1.tx_ready}, 32'd0);
    capture1(2, d, p, s);
    chk("bb_d1", {24'd0, d}, 32'h0000_0001);
    chk("bb_p1", {31'd0, p}, 32'd1);
    chk("bb_s1", {31'd0, s}, 32'd1);
    repeat (7) tick();
    chk("bb_last_stop", {31'd0, tx1},           32'd1);
    chk("bb_ready_175", {31'd0, bus1.tx_ready}, 32'd0);
    tick();
    chk("bb_nogap",     {31'd0, tx1},           32'd0);
    chk("bb_done1",     {31'd0, bus1.tx_done},  32'd1);
    chk("bb_ready_176", {31'd0, bus1.tx_ready}, 32'd1);
    capture1(0, d, p, s);
    chk("bb_d2", {24'd0, d}, 32'h0000_0080);
    chk("bb_p2", {31'd0, p}, 32'd1);
    repeat (8) tick();
    chk("bb_done2", {31'd0, bus1.tx_done}, 32'd1);
    repeat (200) tick();
    chk("ov_idle",   {31'd0, tx1},  32'd1);
    chk("ov_pulses", done1_cnt - snap, 32'd2);

    // Reset during DATA bit 3 with a byte queued.
    write1(8'hF0);
    wait_fall1("rm_fall");
    write1(8'h0F);
    repeat (71) tick();
    snap = done1_cnt;
    rst = 1'b1;
    tick();
    chk("rm_tx",     {31'd0, tx1},            32'd1);
    chk("rm_ready",  {31'd0, bus1.tx_ready},  32'd1);
    chk("rm_active", {31'd0, bus1.tx_active}, 32'd0);
    chk("rm_done",   {31'd0, bus1.tx_done},   32'd0);
    rst = 1'b0;
    repeat (300) tick();
    chk("rm_line_idle", {31'd0, tx1},            32'd1);
    chk("rm_no_done",   done1_cnt - snap,        32'd0);
    chk("rm_discard",   {31'd0, bus1.tx_active}, 32'd0);
    write1(8'h3C);
    wait_fall1("rm2_fall");
    capture1(0, d, p, s);
    chk("rm2_data",   {24'd0, d}, 32'h0000_003C);
    chk("rm2_parity", {31'd0, p}, 32'd0);
    chk("rm2_stop",   {31'd0, s}, 32'd1);
    repeat (8) tick();
    chk("rm2_done", {31'd0, bus1.tx_done}, 32'd1);

    // Gated enable on the two-stop-bit instance: clken every 4th clk, 100-clk freeze in D1.
    line0f = 12'b110000011110;
    freeze = 1'b1;
    bus2.wr_en = 1'b1;
    bus2.din   = 8'h0F;
    tick2();
    bus2.wr_en = 1'b0;
    freeze = 1'b0;
    chk("g_pre_tx", {31'd0, tx2}, 32'd1);
    for (int n = 0; n < 20 && tx2 !== 1'b0; n++) tick2();
    chk("g_fall", {31'd0, tx2}, 32'd0);
    ticks = 0;
    for (int rel = 1; rel <= 880; rel++) begin
      freeze = (rel >= 138) && (rel < 238);
      tick2();
      if (clken2) ticks++;
      exp_tx = (ticks < 192) ? line0f[ticks / 16] : 1'b1;
      chk("g_line", {31'd0, tx2}, {31'd0, exp_tx});
      chk("g_done", {31'd0, bus2.tx_done}, {31'd0, (rel == 868)});
      if (rel == 63)  chk("g_start_end", {31'd0, tx2}, 32'd0);
      if (rel == 64)  chk("g_d0",        {31'd0, tx2}, 32'd1);
      if (rel == 200) chk("g_frozen",    {31'd0, tx2}, 32'd1);
      if (rel == 868) chk("g_inactive",  {31'd0, bus2.tx_active}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
